// File: rtl/fetch_pc_gen.sv
// Fetch-block address generator: issues aligned multi-instruction fetch requests on an
// AXI-style read-address channel, with redirect epochs and outstanding-request credits.
module fetch_pc_gen #(
    parameter int                ADDR_W   = 32,
    parameter int                FETCH_W  = 2,
    parameter int                MAX_OUT  = 4,
    parameter int                EPOCH_W  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               OFF_W    = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               buffer_free,
    input  logic               rdone,
    output logic               arvalid,
    output logic [ADDR_W-1:0]  araddr,
    input  logic               arready,
    output logic [OFF_W-1:0]   ar_offset,
    output logic [EPOCH_W-1:0] ar_epoch,
    output logic [EPOCH_W-1:0] cur_epoch,
    output logic [3:0]         outstanding
);

    localparam logic [ADDR_W-1:0] BLK_BYTES = ADDR_W'(FETCH_W * 4);
    localparam logic [ADDR_W-1:0] SLOT_MASK = ADDR_W'(FETCH_W - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [EPOCH_W-1:0] ar_epoch_q, ar_epoch_d;
    logic [EPOCH_W-1:0] cur_epoch_q, cur_epoch_d;
    logic [3:0]         out_q, out_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;

    logic               hs;
    logic               rdone_eff;
    logic               may_issue;
    logic [ADDR_W-1:0]  jump_tgt;
    logic               unused_jump_lo;

    function automatic logic [ADDR_W-1:0] align_blk(input logic [ADDR_W-1:0] x);
        return x & ~(BLK_BYTES - 1'b1);
    endfunction

    function automatic logic [OFF_W-1:0] slot_of(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] w;
        w = (x >> 2) & SLOT_MASK;
        return w[OFF_W-1:0];
    endfunction

    assign jump_tgt       = {jump_addr[ADDR_W-1:2], 2'b00};
    assign unused_jump_lo = ^jump_addr[1:0];

    assign hs        = (state_q == S_REQ) && arready;
    assign rdone_eff = rdone && (out_q != 4'd0);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        araddr_d    = araddr_q;
        offset_d    = offset_q;
        ar_epoch_d  = ar_epoch_q;
        cur_epoch_d = cur_epoch_q;
        pend_d      = pend_q;
        tgt_d       = tgt_q;
        may_issue   = 1'b0;
        out_d       = out_q + 4'(hs) - 4'(rdone_eff);

        case (state_q)
            S_IDLE: begin
                if (jump) begin
                    pc_d        = jump_tgt;
                    cur_epoch_d = cur_epoch_q + EPOCH_W'(1);
                end
                may_issue = 1'b1;
            end
            S_REQ: begin
                if (hs) begin
                    // A same-cycle jump outranks an older latched redirect.
                    if (jump) begin
                        pc_d        = jump_tgt;
                        cur_epoch_d = cur_epoch_q + EPOCH_W'(1);
                    end else if (pend_q) begin
                        pc_d        = tgt_q;
                        cur_epoch_d = cur_epoch_q + EPOCH_W'(1);
                    end else begin
                        pc_d = align_blk(pc_q) + BLK_BYTES;
                    end
                    pend_d    = 1'b0;
                    state_d   = S_IDLE;
                    may_issue = 1'b1;
                end else if (jump) begin
                    pend_d = 1'b1;
                    tgt_d  = jump_tgt;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (may_issue && buffer_free && !jump && (out_d < 4'(MAX_OUT))) begin
            state_d    = S_REQ;
            araddr_d   = align_blk(pc_d);
            offset_d   = slot_of(pc_d);
            ar_epoch_d = cur_epoch_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            araddr_q    <= RESET_PC;
            offset_q    <= '0;
            ar_epoch_q  <= '0;
            cur_epoch_q <= '0;
            out_q       <= '0;
            pend_q      <= 1'b0;
            tgt_q       <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            araddr_q    <= araddr_d;
            offset_q    <= offset_d;
            ar_epoch_q  <= ar_epoch_d;
            cur_epoch_q <= cur_epoch_d;
            out_q       <= out_d;
            pend_q      <= pend_d;
            tgt_q       <= tgt_d;
        end
    end

    assign arvalid     = (state_q == S_REQ);
    assign araddr      = araddr_q;
    assign ar_offset   = offset_q;
    assign ar_epoch    = ar_epoch_q;
    assign cur_epoch   = cur_epoch_q;
    assign outstanding = out_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: a transaction-level model predicts every cycle's
// channel status and every handshake; a negedge monitor pops and compares.
module tb_fetch_pc_gen;

    localparam int              BLK       = 8;
    localparam int              MAX_OUT   = 4;
    localparam int              EPOCHS    = 4;
    localparam longint unsigned ADDR_SPAN = 64'd1 << 32;

    logic        clk = 1'b0;
    logic        rst, jump, buffer_free, rdone, arready;
    logic [31:0] jump_addr;
    logic        arvalid;
    logic [31:0] araddr;
    logic [0:0]  ar_offset;
    logic [1:0]  ar_epoch, cur_epoch;
    logic [3:0]  outstanding;

    fetch_pc_gen dut (
        .clk        (clk),
        .rst        (rst),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .buffer_free(buffer_free),
        .rdone      (rdone),
        .arvalid    (arvalid),
        .araddr     (araddr),
        .arready    (arready),
        .ar_offset  (ar_offset),
        .ar_epoch   (ar_epoch),
        .cur_epoch  (cur_epoch),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              valid;
        longint unsigned addr;
        int              off;
        int              aep;
        int              cep;
        int              out;
    } stat_t;

    typedef struct {
        longint unsigned addr;
        int              off;
        int              aep;
    } hs_t;

    stat_t stat_q[$];
    hs_t   hs_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: what the channel should present after the latest edge.
    bit              m_valid, m_pend;
    longint unsigned m_pc, m_addr, m_tgt;
    int              m_off, m_aep, m_cep, m_out;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_pend = 0; m_pc = 0; m_addr = 0; m_tgt = 0;
        m_off = 0; m_aep = 0; m_cep = 0; m_out = 0;
    endtask

    task automatic redirect(input longint unsigned t);
        m_pc  = t;
        m_cep = (m_cep + 1) % EPOCHS;
    endtask

    task automatic model_step(input bit r, input bit j, input logic [31:0] ja,
                              input bit bf, input bit rd, input bit ar);
        longint unsigned t;
        bit hs;
        if (r) begin
            model_reset();
            return;
        end
        hs    = m_valid && ar;
        t     = longint'(ja);
        t     = t - (t % 4);
        m_out = m_out + (hs ? 1 : 0) - (rd ? 1 : 0);
        if (m_valid && !hs) begin
            if (j) begin
                m_pend = 1;
                m_tgt  = t;
            end
        end else begin
            if (hs) begin
                m_valid = 0;
                if (!j) begin
                    if (m_pend) redirect(m_tgt);
                    else        m_pc = ((m_pc / BLK) * BLK + BLK) % ADDR_SPAN;
                end
                m_pend = 0;
            end
            if (j) redirect(t);
            if (bf && !j && m_out < MAX_OUT) begin
                m_valid = 1;
                m_addr  = (m_pc / BLK) * BLK;
                m_off   = int'((m_pc % BLK) / 4);
                m_aep   = m_cep;
            end
        end
    endtask

    // One clock cycle of stimulus; rdone is only raised while the model has credits out.
    task automatic cycle(input bit r, input bit j, input logic [31:0] ja,
                         input bit bf, input bit rd_want, input bit ar);
        bit rd;
        @(posedge clk);
        #1;
        rd          = rd_want && (m_out > 0);
        rst         = r;
        jump        = j;
        jump_addr   = ja;
        buffer_free = bf;
        rdone       = rd;
        arready     = ar;
        stat_q.push_back('{m_valid, m_addr, m_off, m_aep, m_cep, m_out});
        if (m_valid && ar) hs_q.push_back('{m_addr, m_off, m_aep});
        model_step(r, j, ja, bf, rd, ar);
    endtask

    // Monitor: compares DUT outputs on the falling edge against popped expectations.
    initial begin
        stat_t s;
        hs_t   h;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("arvalid", 64'(arvalid), 64'(s.valid));
                check("outstanding", 64'(outstanding), 64'(s.out));
                check("cur_epoch", 64'(cur_epoch), 64'(s.cep));
                if (s.valid) begin
                    check("araddr", 64'(araddr), s.addr);
                    check("ar_offset", 64'(ar_offset), 64'(s.off));
                    check("ar_epoch", 64'(ar_epoch), 64'(s.aep));
                end
            end
            if (arvalid === 1'b1 && arready === 1'b1) begin
                if (hs_q.size() == 0) begin
                    check("hs_unexpected", 64'(1), 64'(0));
                end else begin
                    h = hs_q.pop_front();
                    check("hs_addr", 64'(araddr), h.addr);
                    check("hs_offset", 64'(ar_offset), 64'(h.off));
                    check("hs_epoch", 64'(ar_epoch), 64'(h.aep));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; jump = 1'b0; jump_addr = '0;
        buffer_free = 1'b0; rdone = 1'b0; arready = 1'b0;
        model_reset();

        // Sequential stream with a credit returned every cycle.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 1, 1);
            @(negedge clk);
            check("seq_araddr", 64'(araddr), 64'(i * 8));
            check("seq_offset", 64'(ar_offset), 64'(0));
            check("seq_out_le1", 64'(outstanding <= 4'd1), 64'(1));
        end

        // Credit limit: four handshakes then stall until one response returns.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        check("limit_arvalid", 64'(arvalid), 64'(0));
        check("limit_out", 64'(outstanding), 64'(4));
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("credit_arvalid", 64'(arvalid), 64'(1));
        check("credit_araddr", 64'(araddr), 64'h20);

        // Jump while idle to a mid-block target.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h104, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        check("jmp_arvalid", 64'(arvalid), 64'(1));
        check("jmp_araddr", 64'(araddr), 64'h100);
        check("jmp_offset", 64'(ar_offset), 64'(1));
        check("jmp_epoch", 64'(ar_epoch), 64'(1));
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("jmp_next_araddr", 64'(araddr), 64'h108);
        check("jmp_next_offset", 64'(ar_offset), 64'(0));

        // Two jumps while a request at 0x40 is stalled: latest target wins, one epoch step.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 1, 32'h200, 1, 1, 0);
        @(negedge clk);
        check("stall_araddr0", 64'(araddr), 64'h40);
        check("stall_epoch0", 64'(ar_epoch), 64'(0));
        cycle(0, 1, 32'h300, 1, 1, 0);
        @(negedge clk);
        check("stall_araddr1", 64'(araddr), 64'h40);
        cycle(0, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("stall_araddr2", 64'(araddr), 64'h40);
        check("stall_cur_epoch", 64'(cur_epoch), 64'(0));
        cycle(0, 0, 0, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("redir_araddr", 64'(araddr), 64'h300);
        check("redir_cur_epoch", 64'(cur_epoch), 64'(1));
        check("redir_ar_epoch", 64'(ar_epoch), 64'(1));

        // Address wrap at the top of the space.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'hFFFF_FFF8, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 1);
        @(negedge clk);
        check("wrap_top", 64'(araddr), 64'hFFFF_FFF8);
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("wrap_arvalid", 64'(arvalid), 64'(1));
        check("wrap_araddr", 64'(araddr), 64'h0);

        // Reset while a request is stalled with three credits out.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 1);
        cycle(1, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("prerst_arvalid", 64'(arvalid), 64'(1));
        check("prerst_out", 64'(outstanding), 64'(3));
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_out", 64'(outstanding), 64'(0));
        check("rst_araddr", 64'(araddr), 64'h0);
        check("rst_cur_epoch", 64'(cur_epoch), 64'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 999) < 4,
                  $urandom_range(0, 99) < 6,
                  ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom,
                  $urandom_range(0, 99) < 80,
                  $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 60);
        end
        cycle(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("sb_hs_drained", 64'(hs_q.size()), 64'(0));
        check("sb_stat_drained", 64'(stat_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
